// File: rtl/conv_tile_packer_if.sv
// conv_tile_packer_if: narrow word stream in, assembled tile out, each with valid/ready.
interface conv_tile_packer_if #(
    parameter int WORD_W    = 16,
    parameter int TILE_BITS = 100,
    parameter int CNT_W     = 16
);
    logic [WORD_W-1:0]    s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [TILE_BITS-1:0] tile_out;
    logic                 tile_valid;
    logic                 tile_ready;
    logic [CNT_W-1:0]     tile_count;
    modport master (
        input  s_data, s_valid, tile_ready,
        output s_ready, tile_out, tile_valid, tile_count
    );
    modport slave (
        output s_data, s_valid, tile_ready,
        input  s_ready, tile_out, tile_valid, tile_count
    );
endinterface

// File: rtl/conv_tile_packer.sv
// conv_tile_packer: packs stream words row-major, LSB-first into a tile held stable for the convolution stage.
module conv_tile_packer #(
    parameter int WIDTH_IN = 10,
    parameter int WORD_W   = 16,
    parameter int CNT_W    = 16
) (
    input logic               clk,
    input logic               reset,
    input logic               flush,
    conv_tile_packer_if.master bus
);
    localparam int TILE_BITS = WIDTH_IN * WIDTH_IN;
    localparam int BEATS     = (TILE_BITS + WORD_W - 1) / WORD_W;
    localparam int IDX_W     = BEATS > 1 ? $clog2(BEATS) : 1;
    typedef enum logic {FILL, FULL} state_t;
    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TILE_BITS-1:0] tile_q, tile_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 accept, handshake, last;
    assign bus.s_ready    = state_q == FILL || bus.tile_ready;
    assign accept         = bus.s_valid && bus.s_ready && !(flush && state_q == FILL);
    assign handshake      = state_q == FULL && bus.tile_ready;
    assign last           = idx_q == IDX_W'(BEATS - 1);
    assign bus.tile_out   = tile_q;
    assign bus.tile_valid = state_q == FULL;
    assign bus.tile_count = cnt_q;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tile_d  = tile_q;
        cnt_d   = cnt_q + CNT_W'(handshake);
        // excess bits of the final beat fall outside TILE_BITS and are never written
        for (int i = 0; i < TILE_BITS; i++)
            if (accept && i / WORD_W == int'(idx_q)) tile_d[i] = bus.s_data[i % WORD_W];
        if (state_q == FILL) begin
            if (flush) idx_d = '0;
            else if (accept) begin
                idx_d   = last ? '0 : idx_q + IDX_W'(1);
                state_d = last ? FULL : FILL;
            end
        end else if (bus.tile_ready) begin
            // a beat taken during the handshake starts the next tile
            state_d = accept && BEATS == 1 ? FULL : FILL;
            idx_d   = accept && BEATS > 1 ? IDX_W'(1) : '0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            idx_q   <= '0;
            tile_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tile_q  <= tile_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
